// File: rtl/ej32_rs_ctl.sv
// Return-stack controller for ej32. It keeps an on-chip circular cache and spills
// the oldest entry to, or fills from, a memory-resident overflow area.
module ej32_rs_ctl #(
  parameter int unsigned    CDEPTH = 8,
  parameter int unsigned    MDEPTH = 256,
  parameter int unsigned    DSZ    = 32,
  parameter int unsigned    ASZ    = 17,
  parameter logic [ASZ-1:0] SBASE  = 17'h1F000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     rs_op,
  input  logic [DSZ-1:0] r_n,
  output logic [DSZ-1:0] r,
  output logic           busy,
  output logic [8:0]     depth,
  output logic           ovf,
  output logic           unf,
  output logic           mem_req,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_addr,
  output logic [DSZ-1:0] mem_wdata,
  input  logic           mem_ack,
  input  logic [DSZ-1:0] mem_rdata
);

  localparam int unsigned PW = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
  localparam int unsigned CW = $clog2(CDEPTH + 1);
  localparam int unsigned MW = $clog2(MDEPTH + 1);

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_e;
  typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_MOVE} op_e;

  state_e         r_state;
  logic [PW-1:0]  r_head;
  logic [CW-1:0]  r_ccnt;
  logic [MW-1:0]  r_mcnt;
  logic [DSZ-1:0] r_pend;
  logic           r_ovf;
  logic           r_unf;
  logic           r_mem_req;
  logic           r_mem_we;
  logic [ASZ-1:0] r_mem_addr;
  logic [DSZ-1:0] r_mem_wdata;
  logic [DSZ-1:0] r_cache [CDEPTH];

  op_e            w_op;
  logic [PW-1:0]  w_hp1;
  logic [PW-1:0]  w_hm1;
  logic           w_full;
  logic           w_mfull;
  logic           w_ack;
  logic [ASZ-1:0] w_spill_addr;
  logic [ASZ-1:0] w_fill_addr;
  logic           w_cwe;
  logic [PW-1:0]  w_cwa;
  logic [DSZ-1:0] w_cwd;

  assign w_op         = op_e'(rs_op);
  assign w_hp1        = r_head + PW'(1);
  assign w_hm1        = r_head - PW'(1);
  assign w_full       = (r_ccnt == CW'(CDEPTH));
  assign w_mfull      = (r_mcnt == MW'(MDEPTH));
  assign w_ack        = r_mem_req & mem_ack;
  assign w_spill_addr = SBASE + ASZ'(r_mcnt);
  assign w_fill_addr  = SBASE + ASZ'(r_mcnt) - ASZ'(1);

  // Every cache write lands at head+1 except MOVE, which rewrites the top slot.
  // When the cache is full, head+1 is also the oldest slot freed by a spill.
  always_comb begin
    w_cwe = 1'b0;
    w_cwa = w_hp1;
    w_cwd = r_n;
    case (r_state)
      IDLE: begin
        if (w_op == OP_PUSH && !w_full) begin
          w_cwe = 1'b1;
        end else if (w_op == OP_MOVE && r_ccnt != '0) begin
          w_cwe = 1'b1;
          w_cwa = r_head;
        end
      end
      SPILL: begin
        w_cwe = w_ack;
        w_cwd = r_pend;
      end
      FILL: begin
        w_cwe = w_ack;
        w_cwd = mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_cwe) r_cache[w_cwa] <= w_cwd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_head      <= '0;
      r_ccnt      <= '0;
      r_mcnt      <= '0;
      r_pend      <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          case (w_op)
            OP_PUSH: begin
              if (!w_full) begin
                r_head <= w_hp1;
                r_ccnt <= r_ccnt + CW'(1);
              end else if (!w_mfull) begin
                r_pend      <= r_n;
                r_state     <= SPILL;
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= w_spill_addr;
                r_mem_wdata <= r_cache[w_hp1];
              end else begin
                r_ovf <= 1'b1;
              end
            end
            OP_POP: begin
              if (r_ccnt != '0) begin
                r_head <= w_hm1;
                r_ccnt <= r_ccnt - CW'(1);
                if (r_ccnt == CW'(1) && r_mcnt != '0) begin
                  r_state    <= FILL;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= w_fill_addr;
                end
              end else begin
                r_unf <= 1'b1;
              end
            end
            OP_MOVE: begin
              if (r_ccnt == '0) r_unf <= 1'b1;
            end
            default: ;
          endcase
        end
        SPILL: begin
          if (w_ack) begin
            r_mcnt      <= r_mcnt + MW'(1);
            r_head      <= w_hp1;
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end
        end
        FILL: begin
          if (w_ack) begin
            r_mcnt     <= r_mcnt - MW'(1);
            r_ccnt     <= CW'(1);
            r_head     <= w_hp1;
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign r         = (r_ccnt != '0) ? r_cache[r_head] : '0;
  assign busy      = (r_state != IDLE);
  assign depth     = 9'(r_ccnt) + 9'(r_mcnt);
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_ej32_rs_ctl.sv
// Bench for ej32_rs_ctl: directed scenarios plus random op streams, all checked
// against a queue model of the whole return stack and its cached portion.
module tb_ej32_rs_ctl;

  localparam int unsigned CD  = 4;
  localparam int unsigned MD  = 2;
  localparam logic [16:0] SB  = 17'h1F000;
  localparam logic [1:0]  NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, MOVE = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rs_op;
  logic [31:0] r_n, r, mem_wdata, mem_rdata;
  logic        busy, ovf, unf, mem_req, mem_we, mem_ack;
  logic [8:0]  depth;
  logic [16:0] mem_addr;

  always #5 clk = ~clk;

  ej32_rs_ctl #(
    .CDEPTH(CD), .MDEPTH(MD), .DSZ(32), .ASZ(17), .SBASE(SB)
  ) dut (
    .clk(clk), .rst(rst), .rs_op(rs_op), .r_n(r_n), .r(r), .busy(busy),
    .depth(depth), .ovf(ovf), .unf(unf), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  // Model: whole stack bottom-first; the top c entries are cache-resident.
  logic [31:0] st[$];
  int          c;
  logic        m_ovf, m_unf;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] top_exp();
    return (st.size() != 0) ? st[st.size()-1] : 32'h0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "/r"},     r,                   top_exp());
    chk({tag, "/depth"}, 32'(depth),          32'(st.size()));
    chk({tag, "/busy"},  32'(busy),           32'h0);
    chk({tag, "/ovf"},   32'(ovf),            32'(m_ovf));
    chk({tag, "/unf"},   32'(unf),            32'(m_unf));
    chk({tag, "/req"},   32'(mem_req),        32'h0);
    chk({tag, "/addr"},  32'(mem_addr),       32'h0);
    chk({tag, "/wdata"}, mem_wdata,           32'h0);
  endtask

  task automatic chk_mem(input string tag, input logic we, input logic [16:0] a,
                         input logic [31:0] wd);
    chk({tag, "/busy"}, 32'(busy),     32'h1);
    chk({tag, "/req"},  32'(mem_req),  32'h1);
    chk({tag, "/we"},   32'(mem_we),   32'(we));
    chk({tag, "/addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "/dpth"}, 32'(depth),    32'(st.size()));
    if (we) chk({tag, "/wdata"}, mem_wdata, wd);
  endtask

  // Waits 'waits' cycles with the request pending (op hop/hd presented and
  // expected to be ignored), then acks with read data rd.
  task automatic handshake(input int waits, input logic [31:0] rd, input logic we,
                           input logic [16:0] a, input logic [31:0] wd,
                           input logic [1:0] hop, input logic [31:0] hd);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk); rs_op = hop; r_n = hd;
      @(posedge clk); #1;
      chk_mem(we ? "spill_hold" : "fill_hold", we, a, wd);
    end
    @(negedge clk); rs_op = hop; r_n = hd; mem_ack = 1'b1; mem_rdata = rd;
    @(posedge clk); #1;
    mem_ack = 1'b0; rs_op = NOP; mem_rdata = $urandom;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] d, input int waits,
                       input logic [1:0] hop, input logic [31:0] hd);
    int          m;
    logic [31:0] old;
    @(negedge clk);
    rs_op = op; r_n = d; mem_rdata = $urandom;
    mem_ack = ($urandom_range(0, 3) == 0);
    @(posedge clk); #1;
    rs_op = NOP; mem_ack = 1'b0;
    m = st.size() - c;
    case (op)
      PUSH: begin
        if (c < CD) begin
          st.push_back(d); c++;
        end else if (m < MD) begin
          old = st[m];
          chk_mem("spill", 1'b1, SB + 17'(m), old);
          handshake(waits, $urandom, 1'b1, SB + 17'(m), old, hop, hd);
          st.push_back(d);
        end else begin
          m_ovf = 1'b1;
        end
      end
      POP: begin
        if (st.size() == 0) begin
          m_unf = 1'b1;
        end else begin
          void'(st.pop_back()); c--;
          if (c == 0 && st.size() > 0) begin
            m = st.size();
            chk_mem("fill", 1'b0, SB + 17'(m - 1), 32'h0);
            handshake(waits, st[m-1], 1'b0, SB + 17'(m - 1), 32'h0, hop, hd);
            c = 1;
          end
        end
      end
      MOVE: begin
        if (c == 0) m_unf = 1'b1;
        else st[st.size()-1] = d;
      end
      default: ;
    endcase
    chk_idle($sformatf("op%0d", op));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/r"},     r,              32'h0);
    chk({tag, "/busy"},  32'(busy),      32'h0);
    chk({tag, "/depth"}, 32'(depth),     32'h0);
    chk({tag, "/flags"}, {30'h0, ovf, unf}, 32'h0);
    chk({tag, "/req"},   {31'h0, mem_req}, 32'h0);
    chk({tag, "/we"},    32'(mem_we),    32'h0);
    chk({tag, "/addr"},  32'(mem_addr),  32'h0);
    chk({tag, "/wdata"}, mem_wdata,      32'h0);
  endtask

  task automatic model_clear();
    st.delete(); c = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; rs_op = NOP; mem_ack = 1'b0;
    #1; model_clear(); chk_reset("rst");
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    int rnd;
    logic [1:0] op;
    rst = 1'b0; rs_op = NOP; r_n = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_clear();
    #1; chk_reset("por");

    // First op accepted on the first edge after release.
    @(negedge clk); rst = 1'b1; rs_op = PUSH; r_n = 32'd1;
    @(posedge clk); #1; rs_op = NOP;
    st.push_back(32'd1); c = 1;
    chk_idle("first");
    for (int i = 2; i <= 4; i++) do_op(PUSH, 32'(i), 0, NOP, 32'h0);
    do_op(PUSH, 32'd5, 2, MOVE, 32'hDEAD);
    for (int i = 0; i < 4; i++) do_op(POP, 32'h0, 1, PUSH, 32'hBEEF);
    chk("fill_r", r, 32'd1);
    for (int i = 0; i < 5; i++) do_op(PUSH, 32'(16 + i), 1, NOP, 32'h0);
    do_op(PUSH, 32'd7, 0, NOP, 32'h0);
    chk("ovf_set", 32'(ovf), 32'h1);

    do_reset();
    do_op(POP, 32'h0, 0, NOP, 32'h0);
    chk("unf_set", 32'(unf), 32'h1);

    do_reset();
    for (int i = 0; i < 3; i++) do_op(PUSH, 32'(32 + i), 0, NOP, 32'h0);
    do_op(MOVE, 32'hAA, 0, NOP, 32'h0);
    chk("move_r", r, 32'hAA);

    // Reset mid-spill, then a late ack that must be ignored.
    do_op(PUSH, 32'd40, 0, NOP, 32'h0);
    @(negedge clk); rs_op = PUSH; r_n = 32'd41;
    @(posedge clk); #1; rs_op = NOP;
    chk_mem("rspill", 1'b1, SB, 32'd32);
    @(negedge clk); rst = 1'b0;
    #1; model_clear(); chk_reset("rst_spill");
    @(negedge clk); rst = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    chk_idle("late_ack");

    // PUSH held during a spill is taken exactly once after busy drops.
    for (int i = 0; i < 4; i++) do_op(PUSH, 32'(48 + i), 0, NOP, 32'h0);
    do_op(PUSH, 32'd52, 2, PUSH, 32'h77);
    do_op(PUSH, 32'h77, 1, NOP, 32'h0);
    chk("held_depth", 32'(depth), 32'd6);
    do_op(NOP, 32'h0, 0, NOP, 32'h0);

    for (int n = 0; n < 400; n++) begin
      rnd = $urandom_range(0, 99);
      if (rnd < 2) begin
        do_reset();
      end else begin
        op = (rnd < 47) ? PUSH : (rnd < 82) ? POP : (rnd < 92) ? MOVE : NOP;
        do_op(op, $urandom, $urandom_range(0, 3), 2'($urandom), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ej32_rs_ctl.md
EJ32_RS_CTL -- requirements
Module: ej32_rs_ctl

Interface
REQ-001 Parameters SHALL be: CDEPTH, default 8, on-chip return-stack cache entries (power of 2); MDEPTH, default 256, spill-area entries in memory; DSZ, default 32, data width; ASZ, default 17, memory address width; SBASE, default 17'h1F000, spill-area base word address.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low.
REQ-005 rs_op  input  2  0 NOP, 1 PUSH, 2 POP, 3 MOVE (overwrite top).
REQ-006 r_n  input  DSZ  data for PUSH/MOVE.
REQ-007 r  output  DSZ  top of return stack; 0 when stack empty.
REQ-008 busy  output  1  controller not accepting ops.
REQ-009 depth  output  9  total entries (cache + spilled).
REQ-010 ovf  output  1  sticky overflow flag.
REQ-011 unf  output  1  sticky underflow/empty-MOVE flag.
REQ-012 mem_req  output  1  memory request.
REQ-013 mem_we  output  1  1 write (spill), 0 read (fill).
REQ-014 mem_addr  output  ASZ  word address.
REQ-015 mem_wdata  output  DSZ  spill data.
REQ-016 mem_ack  input  1  request completes on rising edge where mem_req and mem_ack are both 1.
REQ-017 mem_rdata  input  DSZ  fill data, valid with mem_ack.

Function
REQ-018 Cache SHALL be a circular buffer with head pointer, count ccnt (0..CDEPTH) and spill count mcnt (0..MDEPTH); depth = ccnt + mcnt.
REQ-019 FSM states SHALL be IDLE, SPILL, FILL; busy = (state != IDLE).
REQ-020 rs_op SHALL be sampled only on edges where busy=0; ops while busy=1 are ignored, requester holds them.
REQ-021 PUSH with ccnt<CDEPTH: r_n written at head+1, ccnt+1; r shows r_n next cycle.
REQ-022 PUSH with ccnt==CDEPTH and mcnt<MDEPTH: r_n latched, go SPILL; mem_req=1, mem_we=1, mem_addr=SBASE+mcnt, mem_wdata=oldest cache entry.
REQ-023 SPILL ack edge: mcnt+1, oldest slot freed, latched r_n pushed, go IDLE; r shows r_n the cycle after ack.
REQ-024 PUSH with ccnt==CDEPTH and mcnt==MDEPTH: op dropped, ovf set, state unchanged.
REQ-025 POP with ccnt>=1: head-1, ccnt-1; if result ccnt==0 and mcnt>0, go FILL next cycle.
REQ-026 FILL: mem_req=1, mem_we=0, mem_addr=SBASE+mcnt-1; ack edge loads mem_rdata as sole cache entry, ccnt=1, mcnt-1, go IDLE.
REQ-027 POP with depth==0: no change, unf set.
REQ-028 MOVE with ccnt>=1: top overwritten with r_n, counts unchanged; MOVE with ccnt==0: dropped, unf set.
REQ-029 mem_req, mem_we, mem_addr, mem_wdata SHALL be stable from request until ack; mem_req=0, address/data 0 in IDLE.
REQ-030 mem_ack while mem_req=0 SHALL be ignored.
REQ-031 Pointers SHALL wrap modulo CDEPTH; mcnt never wraps.
REQ-032 ovf/unf SHALL be cleared only by reset.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, ccnt=0, mcnt=0, head=0, r=0, busy=0, depth=0, ovf=0, unf=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, including mid-SPILL/FILL; cache contents need not be cleared.
REQ-034 First op SHALL be accepted on the first rising edge after rst deasserts.

Verification (CDEPTH=4, MDEPTH=2)
REQ-035 PUSH 1,2,3,4 on consecutive cycles -> r=4, depth=4, busy never 1, mem_req never 1.
REQ-036 Then PUSH 5, ack after 2 wait cycles -> mem_req/we=1, addr=SBASE, wdata=1 held 3 cycles; after ack r=5, depth=5, busy=0.
REQ-037 Then POP x4 -> r=4,3,2 then FILL with addr=SBASE, mem_rdata=1 -> r=1, depth=1.
REQ-038 Fill to depth 6, PUSH 7 -> ovf=1, depth=6, r unchanged; POP from empty after reset -> unf=1, r=0.
REQ-039 Assert rst during SPILL with mem_ack=0 -> mem_req=0, busy=0, depth=0 same cycle; late mem_ack ignored.
REQ-040 MOVE 0xAA with depth=3 -> r=0xAA, depth=3; PUSH held while busy=1 -> accepted once only after busy=0.
